// File: rtl/mux_test_pkg.sv
// Shared definitions for the 2:1 mux stimulus sequencer: FSM encoding, widths,
// the expected mux truth table and a popcount helper.
package mux_test_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   localparam int unsigned VEC_W = 3;

   // Bit index = {x1,s,x2}; f = s ? x2 : x1.
   localparam logic [7:0] MUX2_EXPECTED = 8'hB8;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/hold_timer.sv
// Hold-window counter: counts while enabled and strobes on the last cycle of
// each window, wrapping to zero there.
module hold_timer #(
   parameter int unsigned HOLD_CYCLES = 100
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic sample
);

   localparam logic [15:0] LastCnt = 16'(HOLD_CYCLES - 1);

   logic [15:0] cnt_q, cnt_d;

   assign sample = en && (cnt_q == LastCnt);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = 16'd0;
      end else if (en) begin
         cnt_d = sample ? 16'd0 : cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mux_stim_sequencer.sv
// Walks {x1,s,x2} through all eight combinations, captures the mux output f at
// the end of each hold window and grades the observed truth table.
module mux_stim_sequencer
   import mux_test_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 100,
   parameter logic [7:0]  EXPECTED    = MUX2_EXPECTED
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       f,
   output logic       x1,
   output logic       s,
   output logic       x2,
   output logic       busy,
   output logic       done,
   output logic [7:0] truth,
   output logic       pass,
   output logic [3:0] mismatch_cnt
);

   state_e           state_q, state_d;
   logic [VEC_W-1:0] vec_q, vec_d;
   logic [VEC_W-1:0] vec_out_q, vec_out_d;
   logic [7:0]       truth_q, truth_d;
   logic             pass_q, pass_d;
   logic [3:0]       mm_q, mm_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             sample;

   hold_timer #(
      .HOLD_CYCLES(HOLD_CYCLES)
   ) u_hold_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (state_q != StRun),
      .en     (state_q == StRun),
      .sample (sample)
   );

   // Outputs are computed one cycle ahead so every port comes straight from a flop.
   always_comb begin
      state_d   = state_q;
      vec_d     = vec_q;
      vec_out_d = '0;
      truth_d   = truth_q;
      pass_d    = pass_q;
      mm_d      = mm_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               vec_d   = '0;
               truth_d = 8'd0;
               pass_d  = 1'b0;
               mm_d    = 4'd0;
               busy_d  = 1'b1;
            end
         end
         StRun: begin
            busy_d    = 1'b1;
            vec_out_d = vec_q;
            if (sample) begin
               truth_d[vec_q] = f;
               if (vec_q == 3'd7) begin
                  state_d   = StDone;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
                  vec_out_d = '0;
                  pass_d    = (truth_d == EXPECTED);
                  mm_d      = popcount8(truth_d ^ EXPECTED);
               end else begin
                  vec_d     = vec_q + 3'd1;
                  vec_out_d = vec_q + 3'd1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         vec_q     <= '0;
         vec_out_q <= '0;
         truth_q   <= 8'd0;
         pass_q    <= 1'b0;
         mm_q      <= 4'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         vec_q     <= vec_d;
         vec_out_q <= vec_out_d;
         truth_q   <= truth_d;
         pass_q    <= pass_d;
         mm_q      <= mm_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign {x1, s, x2}  = vec_out_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign truth        = truth_q;
   assign pass         = pass_q;
   assign mismatch_cnt = mm_q;

endmodule
